// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard, stall and forwarding control for the 5-stage pipeline.
//   Decides each cycle whether PC / F/D hold (StallF/StallD) and whether F/D or
//   D/E are cleared (FlushD/FlushE). Produces the operand-forwarding selects for
//   the D-stage comparator (ForwardAD/BD) and the E-stage ALU (ForwardAE/BE).
//   Sequences the multi-cycle multiply/divide unit (MDBusy/MDDone).
//   Counts stall cycles (StallCount).
// Ports:
//   CLK, Reset                     clock, synchronous active-high reset
//   RsD/RtD, RsE/RtE               source registers in D and E
//   WriteRegE/M/W, RegWriteE/M/W   destination register and write enable per stage
//   MemtoRegE/M                    stage holds a load
//   BranchD, PCSrcD                D holds a branch / D redirects the PC
//   MDStartE, MDOpE, MDUseD        mul/div issue in E, op (1 = div), D uses HI/LO
//   StallF, StallD, FlushD, FlushE pipeline register control
//   ForwardAD/BD, ForwardAE/BE     forwarding selects
//   MDBusy, MDDone, StallCount     mul/div status, stall-cycle counter
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        BranchD,
  input  logic        PCSrcD,
  input  logic        MDStartE,
  input  logic        MDOpE,
  input  logic        MDUseD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MDBusy,
  output logic        MDDone,
  output logic [31:0] StallCount
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  // cnt only ever holds N-1, so clog2(N) bits are enough
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

  md_state_t     state;
  logic [CW-1:0] cnt;
  logic          lwstall, branchstall, mdstall, stall;

  // register 0 is hard-wired, so a compare against it never counts as a hazard
  function automatic logic match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && match(rs, WriteRegM))      return 2'b10;
    else if (RegWriteW && match(rs, WriteRegW)) return 2'b01;
    else                                        return 2'b00;
  endfunction

  always_comb begin
    MDBusy      = 1'b0;
    MDDone      = 1'b0;
    ForwardAE   = 2'b00;
    ForwardBE   = 2'b00;
    ForwardAD   = 1'b0;
    ForwardBD   = 1'b0;
    lwstall     = 1'b0;
    branchstall = 1'b0;
    mdstall     = 1'b0;
    stall       = 1'b0;
    StallF      = 1'b0;
    StallD      = 1'b0;
    FlushD      = 1'b1;   // reset flushes both front registers
    FlushE      = 1'b1;
    if (!Reset) begin
      MDBusy      = (state == BUSY);
      MDDone      = (state == DONE);
      ForwardAE   = fwd_sel(RsE);
      ForwardBE   = fwd_sel(RtE);
      ForwardAD   = RegWriteM && match(RsD, WriteRegM);
      ForwardBD   = RegWriteM && match(RtD, WriteRegM);
      lwstall     = MemtoRegE && (match(RtE, RsD) || match(RtE, RtD));
      branchstall = BranchD &&
                    ((RegWriteE && (match(WriteRegE, RsD) || match(WriteRegE, RtD))) ||
                     (MemtoRegM && (match(WriteRegM, RsD) || match(WriteRegM, RtD))));
      mdstall     = MDUseD && (MDBusy || MDStartE);
      stall       = lwstall || branchstall || mdstall;
      StallF      = stall;
      StallD      = stall;
      FlushE      = stall;
      // a redirect resolved on stale operands must not flush F/D
      FlushD      = PCSrcD && !stall;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      StallCount <= '0;
    end else begin
      if (StallD) StallCount <= StallCount + 32'd1;
      case (state)
        IDLE, DONE: begin
          // DONE accepts a new start so back-to-back ops have no idle gap
          if (MDStartE) begin
            cnt   <= MDOpE ? DIV_LD : MUL_LD;
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and stall controller for the 5-stage pipeline. It decides, every cycle, whether each pipeline register advances, holds or is cleared: its StallD output drives the F/D register enable (inverted) and FlushD drives its clear. It also produces the operand-forwarding selects and sequences the multi-cycle multiply/divide unit. It sits beside the datapath and takes register-number and control bits from the D, E, M and W stages.

## Interface
- MUL_CYCLES, 4, busy cycles for a multiply (≥1)
- DIV_CYCLES, 32, busy cycles for a divide (≥1)

- CLK  in  1  clock; all state updates on its rising edge
- Reset  in  1  synchronous, active-high reset
- RsD, RtD  in  5  source registers of the instruction in D
- RsE, RtE  in  5  source registers of the instruction in E
- WriteRegE, WriteRegM, WriteRegW  in  5  destination registers in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1  the stage writes the register file
- MemtoRegE, MemtoRegM  in  1  the stage holds a load
- BranchD  in  1  D holds a branch (compared in D)
- PCSrcD  in  1  D redirects the PC (taken branch or jump)
- MDStartE  in  1  E issues a multiply/divide
- MDOpE  in  1  0 = multiply, 1 = divide
- MDUseD  in  1  D reads HI/LO or issues a multiply/divide
- StallF, StallD  out  1  hold PC / hold F/D register
- FlushD, FlushE  out  1  clear F/D / clear D/E register
- ForwardAD, ForwardBD  out  1  forward ALUOutM to the D-stage comparator (operand A / operand B)
- ForwardAE, ForwardBE  out  2  E-stage operand select: 00 = register file, 01 = ResultW, 10 = ALUOutM
- MDBusy  out  1  multiply/divide unit computing
- MDDone  out  1  single-cycle pulse: HI/LO valid
- StallCount  out  32  count of cycles in which StallD = 1

## Operation
- Register 0 never matches: any compare against a source or destination of 0 is false.
- ForwardAE:
  - 10 if RsE == WriteRegM and RegWriteM.
  - Otherwise 01 if RsE == WriteRegW and RegWriteW.
  - Otherwise 00.
  - ForwardBE uses the same rule with RtE. The M stage has priority over W.
- ForwardAD = RsD == WriteRegM and RegWriteM. ForwardBD uses the same rule with RtD.
- lwstall = MemtoRegE and RtE ≠ 0 and (RtE == RsD or RtE == RtD).
- branchstall = BranchD and either of:
  - RegWriteE and WriteRegE is in {RsD, RtD};
  - MemtoRegM and WriteRegM is in {RsD, RtD}.
- mdstall = MDUseD and (MDBusy or MDStartE).
- Stall and flush outputs:
  - stall = lwstall | branchstall | mdstall.
  - StallF = StallD = stall.
  - FlushE = stall, which inserts a bubble into E.
  - FlushD = PCSrcD & ~stall. A redirect computed from stale operands is suppressed.
- Multiply/divide FSM, states IDLE, BUSY, DONE:
  - IDLE: if MDStartE, load cnt = (MDOpE ? DIV_CYCLES : MUL_CYCLES) − 1 and go to BUSY.
  - BUSY: decrement cnt each cycle. In the cycle where cnt == 0, go to DONE.
  - DONE: accepts a new MDStartE exactly as IDLE does (back-to-back issue). Otherwise go to IDLE.
  - MDStartE while BUSY is ignored. It cannot arise legally because mdstall holds D; the bench asserts it never occurs.
  - MDBusy = (state == BUSY). MDDone = (state == DONE).
- StallCount increments by 1 in every cycle with StallD = 1. It wraps from 2^32−1 to 0.

## Timing
- Forward, stall and flush outputs are combinational from the current inputs and the FSM state, and are valid in the same cycle.
- Multiply/divide latency: MDStartE sampled at edge t gives MDBusy = 1 for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES), then MDDone = 1 for one cycle.
- A D-stage instruction with MDUseD = 1 leaves D in the DONE cycle.
- Reset (synchronous, sampled at the edge):
  - FSM returns to IDLE, cnt = 0, StallCount = 0.
  - Reset mid-operation abandons the operation with no MDDone pulse.
- While Reset = 1:
  - StallF = StallD = 0.
  - FlushD = FlushE = 1.
  - All Forward* = 0.
  - MDBusy = MDDone = 0.
- Simultaneous events:
  - lwstall and PCSrcD together: stall wins and FlushD = 0.
  - MDStartE with MDUseD: stall, and the FSM starts.

## Test plan
- Load-use: MemtoRegE = 1, RtE = 5, RsD = 5 → StallF = StallD = FlushE = 1, FlushD = 0. Repeat with RtE = 0 → no stall.
- Forwarding priority: RsE = 3, WriteRegM = WriteRegW = 3, RegWriteM = RegWriteW = 1 → ForwardAE = 10. Drop RegWriteM → ForwardAE = 01. With RsE = 0 → ForwardAE = 00.
- Branch: BranchD = 1, RsD = 7, RegWriteE = 1, WriteRegE = 7, PCSrcD = 1 → stall = 1, FlushD = 0. On the next cycle, with E cleared and RegWriteM = 1, WriteRegM = 7 → ForwardAD = 1, FlushD = 1.
- Divide: pulse MDStartE, MDOpE = 1, with MDUseD = 1 held → MDBusy high for 32 cycles, StallD high for 33 cycles, MDDone pulse on cycle 33, StallCount = 33.
- Back-to-back multiply: new MDStartE in the DONE cycle → BUSY for 4 more cycles with no IDLE gap.
- Reset in cycle 10 of a divide → MDBusy = 0 next cycle, no MDDone, StallCount = 0. During Reset, FlushD = FlushE = 1.
